wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
Schedules functional-unit write-back results onto the register file's limited write ports. Arbitration is round-robin.
- Sits between the execute-stage units (ADD0/1, MUL hi/lo, FADD0/1, FMUL, LOGIC) and the register file.
- Replaces direct per-unit writeReg calls.
- Raises a stall to the issue stage when a result cannot be retired in the current cycle.

Parameters:
NUM_REQ, 8, number of write-back requesters (one per result bus)
NUM_WP, 2, number of register-file write ports
DATA_W, 32, result data width
ADDR_W, 5, register address width (32 registers, r0 hardwired zero)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester i holds a result
req_addr  input  NUM_REQ*ADDR_W  destination register for requester i (slice i)
req_data  input  NUM_REQ*DATA_W  result data for requester i (slice i)
req_ready  output  NUM_REQ  requester i accepted this cycle (combinational)
wp_en  output  NUM_WP  write enable per register-file port (registered)
wp_addr  output  NUM_WP*ADDR_W  write address per port (registered)
wp_data  output  NUM_WP*DATA_W  write data per port (registered)
stall_issue  output  1  at least one valid requester not accepted this cycle (combinational)

Behaviour:
- Single clock domain (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - wp_en=0, wp_addr=0, wp_data=0.
  - Round-robin pointer rr_ptr=0.
  - While rst_n=0: req_ready=0, stall_issue=0.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A requester must hold addr/data stable until accepted.
  - req_ready is never asserted without req_valid.
- Arbitration, each cycle:
  - Scan requesters starting at rr_ptr, in order rr_ptr, rr_ptr+1, ..., with wrap modulo NUM_REQ.
  - Grant up to NUM_WP valid requests.
  - Grant k is assigned to write port k, in scan order.
- r0 filter: a valid request with addr==0 is accepted (req_ready=1) and does not consume a port. No write is issued for it.
- Same-address rule:
  - At most one grant per destination address per cycle.
  - A later-in-scan request to an address already granted this cycle is not accepted. It retries next cycle.
- Latency: an accepted request appears on wp_en/addr/data exactly 1 cycle after acceptance, for one cycle only.
- Idle ports: wp_en[k]=0; wp_addr/wp_data hold their previous value.
- Pointer update:
  - If any non-r0 grant occurred, rr_ptr = (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap at NUM_REQ-1 -> 0.
- Fairness: with all NUM_REQ requesters continuously valid to distinct addresses, each is granted at least once every ceil(NUM_REQ/NUM_WP) cycles.
- stall_issue = OR over i of (req_valid[i] & ~req_ready[i]).
- Reset mid-operation:
  - Pending un-accepted requests are dropped by the arbiter.
  - Outputs return to reset values immediately (asynchronous).
  - The first arbitration after release starts from requester 0.
- All requesters idle: wp_en=0 next cycle, stall_issue=0, rr_ptr unchanged.

Optional Feature:
Macro: WB_ARB_STATS_EN
- Defined: adds three outputs, each a 16-bit counter.
  - stat_grants: number of non-r0 writes issued.
  - stat_stall_cycles: cycles with stall_issue=1.
  - stat_addr_conflicts: requests deferred by the same-address rule.
  - Counters reset to 0 on rst_n=0, saturate at 16'hFFFF, and update on the same edge as wp_en.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- Reset release, all req_valid=0 for 5 cycles -> wp_en=0, stall_issue=0, req_ready=0 every cycle.
- req_valid=8'b0000_0011; req0 -> r3=32'h11, req1 -> r4=32'h22 -> both ready same cycle, stall_issue=0. Next cycle:
  - wp_en=2'b11
  - port0 = (r3, 32'h11)
  - port1 = (r4, 32'h22)
  - rr_ptr=2
- All 8 valid, distinct addresses r1..r8, held until accepted:
  - Grants proceed in pairs {0,1},{2,3},{4,5},{6,7} over 4 cycles.
  - stall_issue=1 for the first 3 cycles, 0 in the 4th.
- req2 and req5 both target r9 with rr_ptr=0 -> cycle 1: req2 granted, req5 deferred, stall_issue=1. Cycle 2: req5 granted; r9 written twice in order req2 then req5.
- req0 addr=0 and req1 addr=r7 -> both ready in one cycle; next cycle only port0 writes r7, wp_en=2'b01.
- rst_n pulled low while 4 requests pending -> outputs 0 asynchronously. After release with requests held: the first grants are req0 and req1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin write-back arbiter onto register-file write ports
//
// Purpose:
//   Collects functional-unit results and retires up to NUM_WP of them per cycle
//   onto the register-file write ports. The scan starts at a rotating pointer so
//   every requester gets a fair turn. Writes to r0 are accepted but never issued,
//   and only one write per destination register is allowed per cycle.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid       per-requester result present
//   req_addr        per-requester destination register (slice i)
//   req_data        per-requester result data (slice i)
//   req_ready       per-requester accept this cycle (combinational)
//   wp_en           per-port write enable (registered)
//   wp_addr         per-port write address (registered, holds when idle)
//   wp_data         per-port write data (registered, holds when idle)
//   stall_issue     some valid requester was not accepted this cycle
//
// Optional build macro WB_ARB_STATS_EN adds saturating 16-bit counters:
//   stat_grants, stat_stall_cycles, stat_addr_conflicts.

module wb_port_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int NUM_WP  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_WP-1:0]          wp_en,
  output logic [NUM_WP*ADDR_W-1:0]   wp_addr,
  output logic [NUM_WP*DATA_W-1:0]   wp_data,
  output logic                       stall_issue
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]                stat_grants,
  output logic [15:0]                stat_stall_cycles,
  output logic [15:0]                stat_addr_conflicts
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          next_ptr_c;
  logic [NUM_REQ-1:0]        ready_c;
  logic [NUM_WP-1:0]         gnt_en_c;
  logic [NUM_WP*ADDR_W-1:0]  gnt_addr_c;
  logic [NUM_WP*DATA_W-1:0]  gnt_data_c;
  logic [ADDR_W-1:0]         cur_addr;
  logic                      dup;
  logic                      stall_c;
  int                        idx;
  int                        n_gnt;
`ifdef WB_ARB_STATS_EN
  int                        n_conf;
`endif

  // Scan in rotated order; grant k goes to port k. An address already claimed
  // by an earlier grant this cycle blocks later requests to the same register.
  always_comb begin
    ready_c    = '0;
    gnt_en_c   = '0;
    gnt_addr_c = '0;
    gnt_data_c = '0;
    next_ptr_c = rr_ptr;
    cur_addr   = '0;
    dup        = 1'b0;
    idx        = 0;
    n_gnt      = 0;
`ifdef WB_ARB_STATS_EN
    n_conf     = 0;
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      idx      = (int'(rr_ptr) + j) % NUM_REQ;
      cur_addr = req_addr[idx*ADDR_W +: ADDR_W];
      if (req_valid[idx]) begin
        if (cur_addr == '0) begin
          // r0 writes are discarded, so they never need a port.
          ready_c[idx] = 1'b1;
        end else begin
          dup = 1'b0;
          for (int k = 0; k < NUM_WP; k++) begin
            if (gnt_en_c[k] && (gnt_addr_c[k*ADDR_W +: ADDR_W] == cur_addr)) begin
              dup = 1'b1;
            end
          end
          if (dup) begin
`ifdef WB_ARB_STATS_EN
            n_conf = n_conf + 1;
`endif
          end else if (n_gnt < NUM_WP) begin
            ready_c[idx]                        = 1'b1;
            gnt_en_c[n_gnt]                     = 1'b1;
            gnt_addr_c[n_gnt*ADDR_W +: ADDR_W]  = cur_addr;
            gnt_data_c[n_gnt*DATA_W +: DATA_W]  = req_data[idx*DATA_W +: DATA_W];
            n_gnt                               = n_gnt + 1;
            next_ptr_c                          = PTR_W'((idx + 1) % NUM_REQ);
          end
        end
      end
    end
    stall_c = |(req_valid & ~ready_c);
  end

  // Handshake outputs are forced low while reset is held.
  assign req_ready   = rst_n ? ready_c : '0;
  assign stall_issue = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_en   <= '0;
      wp_addr <= '0;
      wp_data <= '0;
      rr_ptr  <= '0;
    end else begin
      wp_en  <= gnt_en_c;
      rr_ptr <= next_ptr_c;
      for (int k = 0; k < NUM_WP; k++) begin
        if (gnt_en_c[k]) begin
          wp_addr[k*ADDR_W +: ADDR_W] <= gnt_addr_c[k*ADDR_W +: ADDR_W];
          wp_data[k*DATA_W +: DATA_W] <= gnt_data_c[k*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants         <= '0;
      stat_stall_cycles   <= '0;
      stat_addr_conflicts <= '0;
    end else begin
      stat_grants         <= sat_add(stat_grants, 16'($countones(gnt_en_c)));
      stat_stall_cycles   <= sat_add(stat_stall_cycles, {15'd0, stall_c});
      stat_addr_conflicts <= sat_add(stat_addr_conflicts, 16'(n_conf));
    end
  end
`endif

endmodule
